ahbl_master_arbiter: RTL



---
 rtl/ahbl_master_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter: AHB-Lite master-port arbiter. It decides which master
// owns the shared address phase and tracks the data-phase owner on its own, so
// a pipelined transfer always completes on the master that issued it.
// Policy: one fixed high-priority master, round-robin among the others, a
// limit on consecutive granted beats, and HMASTLOCK sequences that are never
// split.
// Optional feature: define ARB_HANG_DETECT_EN to build in the bus-hang
// watchdog. Without it, hang_err is tied low.
module ahbl_master_arbiter #(
  parameter int NM             = 2,
  parameter int HIGH_PRIO      = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  parameter int TIMEOUT        = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NM-1:0]         req,
  input  logic [NM-1:0]         lock,
  input  logic                  hready,
  output logic [NM-1:0]         grant_addr,
  output logic [NM-1:0]         grant_data,
  output logic [$clog2(NM)-1:0] addr_sel,
  output logic [$clog2(NM)-1:0] data_sel,
  output logic                  hmastlock,
  output logic [NM-1:0]         stall,
  output logic                  hang_err
);

  localparam int SW = $clog2(NM);
  // The hold counter saturates at MAX_HOLD-1, which means "the next beat is the last".
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  // HIGH_PRIO == NM (or any out-of-range value) turns fixed priority off.
  localparam logic [NM-1:0] HP_MASK   = (HIGH_PRIO >= 0 && HIGH_PRIO < NM) ?
                                        (NM'(1) << HIGH_PRIO) : {NM{1'b0}};
  localparam logic [SW-1:0] HP_IDX    = SW'((HIGH_PRIO >= 0 && HIGH_PRIO < NM) ? HIGH_PRIO : 0);
  localparam logic [SW-1:0] DEF_IDX   = SW'(DEFAULT_MASTER);
  localparam logic [NM-1:0] DEF_GRANT = NM'(1) << DEFAULT_MASTER;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_r;
  logic [HW-1:0] hold_cnt_r;
  logic [SW-1:0] rr_ptr_r;

  logic          owner_req_s;
  logic          owner_lock_s;
  logic          hold_last_s;
  logic [NM-1:0] arb_req_s;
  logic          win_valid_s;
  logic [SW-1:0] win_idx_s;
  logic          win_hp_s;
  state_t        rearb_state_s;
  logic [NM-1:0] rearb_grant_s;
  logic [SW-1:0] rearb_sel_s;
  logic [SW-1:0] rearb_rr_s;

  // The high-priority master wins outright. Otherwise scan round-robin,
  // starting just after the last round-robin winner. The high-priority master
  // is excluded implicitly because it is not requesting on that path.
  function automatic logic [SW:0] pick_winner(input logic [NM-1:0] r,
                                              input logic [SW-1:0] ptr);
    logic [SW:0] res;
    int          c;
    res = '0;
    if ((r & HP_MASK) != {NM{1'b0}}) begin
      res = {1'b1, HP_IDX};
    end else begin
      for (int k = 1; k <= NM; k++) begin
        c = (int'(ptr) + k) % NM;
        if (!res[SW] && r[c]) begin
          res = {1'b1, SW'(c)};
        end else begin
          res = res;
        end
      end
    end
    return res;
  endfunction

  // Compute the next-owner candidate and the outcome of a re-arbitration.
  always_comb begin
    owner_req_s  = req[addr_sel];
    owner_lock_s = lock[addr_sel];
    hold_last_s  = (hold_cnt_r >= HOLD_LAST);
    // When parked, every requester is a candidate (including the park master).
    // Otherwise the current owner competes only by keeping its grant.
    arb_req_s    = (state_r == PARK) ? req : (req & ~grant_addr);
    {win_valid_s, win_idx_s} = pick_winner(arb_req_s, rr_ptr_r);
    win_hp_s     = win_valid_s && HP_MASK[win_idx_s];
    if (win_valid_s) begin
      rearb_state_s = OWN;
      rearb_grant_s = NM'(1) << win_idx_s;
      rearb_sel_s   = win_idx_s;
    end else begin
      rearb_state_s = PARK;
      rearb_grant_s = DEF_GRANT;
      rearb_sel_s   = DEF_IDX;
    end
    rearb_rr_s = (win_valid_s && !win_hp_s) ? win_idx_s : rr_ptr_r;
  end

  // Arbitration FSM. It also registers the grant, select, lock and data-phase
  // outputs. Nothing moves while hready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= PARK;
      grant_addr <= DEF_GRANT;
      addr_sel   <= DEF_IDX;
      grant_data <= {NM{1'b0}};
      data_sel   <= {SW{1'b0}};
      hmastlock  <= 1'b0;
      hold_cnt_r <= {HW{1'b0}};
      rr_ptr_r   <= {SW{1'b0}};
    end else if (hready) begin
      // The address phase accepted on this beat becomes the next data phase.
      grant_data <= grant_addr & {NM{owner_req_s}};
      data_sel   <= owner_req_s ? addr_sel : {SW{1'b0}};
      case (state_r)
        PARK: begin
          if (win_valid_s) begin
            state_r    <= rearb_state_s;
            grant_addr <= rearb_grant_s;
            addr_sel   <= rearb_sel_s;
            hold_cnt_r <= {HW{1'b0}};
            rr_ptr_r   <= rearb_rr_s;
          end else begin
            state_r <= PARK;
          end
        end
        OWN: begin
          if (owner_lock_s) begin
            state_r    <= LOCKED;
            hmastlock  <= 1'b1;
            hold_cnt_r <= {HW{1'b0}};
          end else if (!owner_req_s || (hold_last_s && win_valid_s)) begin
            state_r    <= rearb_state_s;
            grant_addr <= rearb_grant_s;
            addr_sel   <= rearb_sel_s;
            hold_cnt_r <= {HW{1'b0}};
            rr_ptr_r   <= rearb_rr_s;
          end else if (!hold_last_s) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        LOCKED: begin
          // The hold limit does not apply here. Once the lock is released,
          // an idle owner hands over on the same beat.
          if (!owner_lock_s) begin
            hmastlock  <= 1'b0;
            hold_cnt_r <= {HW{1'b0}};
            if (!owner_req_s) begin
              state_r    <= rearb_state_s;
              grant_addr <= rearb_grant_s;
              addr_sel   <= rearb_sel_s;
              rr_ptr_r   <= rearb_rr_s;
            end else begin
              state_r <= OWN;
            end
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r    <= PARK;
          grant_addr <= DEF_GRANT;
          addr_sel   <= DEF_IDX;
          hmastlock  <= 1'b0;
          hold_cnt_r <= {HW{1'b0}};
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign stall = req & ~grant_addr;

`ifdef ARB_HANG_DETECT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] hang_cnt_r;

  // Count consecutive wait states on an active data phase. The flag is sticky
  // until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hang_cnt_r <= {TW{1'b0}};
      hang_err   <= 1'b0;
    end else if (hready) begin
      hang_cnt_r <= {TW{1'b0}};
    end else if (grant_data != {NM{1'b0}} && !hang_err) begin
      hang_cnt_r <= hang_cnt_r + TW'(1);
      if (hang_cnt_r == TW'(TIMEOUT - 1)) begin
        hang_err <= 1'b1;
      end else begin
        hang_err <= hang_err;
      end
    end else begin
      hang_cnt_r <= hang_cnt_r;
    end
  end
`else
  // Watchdog not built: the flag stays low. TIMEOUT is only meaningful when
  // the watchdog exists.
  assign hang_err = (TIMEOUT < 0);
`endif

endmodule
